// File: rtl/step_counter.sv
// Parametrised N-bit up/down step counter over the range 0..LIMIT, with wrap or saturate
// at the boundaries, parallel load, a registered terminal-count pulse and a sticky overflow flag.
module step_counter #(
  parameter int unsigned N        = 8,
  parameter int unsigned LIMIT    = 2**N - 1,
  parameter bit          SAT_MODE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         sclr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         dir,
  input  logic [N-1:0] step,
  input  logic         clr_ovf,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         ovf
);

  localparam logic [N-1:0] LimN = N'(LIMIT);
  localparam logic [N:0]   LimW = (N+1)'(LIMIT);
  localparam logic [N:0]   ModW = (N+1)'(LIMIT + 1);

  logic [N-1:0] s_eff;
  logic [N-1:0] count_d;
  logic [N:0]   sum_up;
  logic [N:0]   wrap_up;
  logic [N:0]   wrap_dn;
  logic         evt;
  logic         tc_d;
  logic         ovf_d;

  always_comb begin
    // Clamping the step to LIMIT keeps every wrap a single subtraction/addition of LIMIT+1.
    s_eff   = (step > LimN) ? LimN : step;
    sum_up  = {1'b0, count} + {1'b0, s_eff};
    wrap_up = sum_up - ModW;
    wrap_dn = {1'b0, count} + ModW - {1'b0, s_eff};
    evt     = 1'b0;
    count_d = count;

    if (sclr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > LimN) ? LimN : load_val;
    end else if (ena) begin
      if (!dir) begin
        if (sum_up > LimW) begin
          evt     = 1'b1;
          count_d = SAT_MODE ? LimN : wrap_up[N-1:0];
        end else begin
          count_d = sum_up[N-1:0];
        end
      end else begin
        if (s_eff <= count) begin
          count_d = count - s_eff;
        end else begin
          evt     = 1'b1;
          count_d = SAT_MODE ? '0 : wrap_dn[N-1:0];
        end
      end
    end

    tc_d  = evt;
    // A boundary event on the same edge beats a clear request.
    ovf_d = evt | (ovf & ~clr_ovf);
  end

  // State updates on the falling edge to line up with the existing counters.
  always_ff @(negedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_d;
      tc    <= tc_d;
      ovf   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter: two instances (3-bit wrap, LIMIT=5; 4-bit saturate, LIMIT=15),
// directed scenarios then random stimulus, checked through a scoreboard against a reference model.
module tb_step_counter;

  typedef struct {
    int count;
    bit tc;
    bit ovf;
  } exp_t;

  logic       clk;
  logic       rst_v  [2];
  logic       ena_v  [2];
  logic       sclr_v [2];
  logic       load_v [2];
  logic       dir_v  [2];
  logic       clr_v  [2];
  logic [3:0] step_v [2];
  logic [3:0] lv_v   [2];

  logic [2:0] cnt0;
  logic [3:0] cnt1;
  logic       tc0, tc1, ovf0, ovf1;

  int   lim   [2] = '{5, 15};
  bit   satm  [2] = '{1'b0, 1'b1};
  int   mask  [2] = '{7, 15};
  int   m_cnt [2];
  bit   m_tc  [2];
  bit   m_ovf [2];
  exp_t q0[$];
  exp_t q1[$];

  int vectors     = 0;
  int miscompares = 0;

  step_counter #(.N(3), .LIMIT(5), .SAT_MODE(1'b0)) u_wrap (
    .clk      (clk),
    .rst      (rst_v[0]),
    .ena      (ena_v[0]),
    .sclr     (sclr_v[0]),
    .load     (load_v[0]),
    .load_val (lv_v[0][2:0]),
    .dir      (dir_v[0]),
    .step     (step_v[0][2:0]),
    .clr_ovf  (clr_v[0]),
    .count    (cnt0),
    .tc       (tc0),
    .ovf      (ovf0)
  );

  step_counter #(.N(4), .LIMIT(15), .SAT_MODE(1'b1)) u_sat (
    .clk      (clk),
    .rst      (rst_v[1]),
    .ena      (ena_v[1]),
    .sclr     (sclr_v[1]),
    .load     (load_v[1]),
    .load_val (lv_v[1]),
    .dir      (dir_v[1]),
    .step     (step_v[1]),
    .clr_ovf  (clr_v[1]),
    .count    (cnt1),
    .tc       (tc1),
    .ovf      (ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: one edge of behaviour computed from the counting rules in plain integers.
  function automatic void model(int k);
    int  L, s, t, lvv;
    bit  e;
    L   = lim[k];
    e   = 1'b0;
    lvv = int'(lv_v[k]) & mask[k];
    s   = int'(step_v[k]) & mask[k];
    if (s > L) s = L;
    if (rst_v[k]) begin
      m_cnt[k] = 0;
      m_tc[k]  = 1'b0;
      m_ovf[k] = 1'b0;
      return;
    end
    if (sclr_v[k]) m_cnt[k] = 0;
    else if (load_v[k]) m_cnt[k] = (lvv > L) ? L : lvv;
    else if (ena_v[k]) begin
      if (!dir_v[k]) begin
        t = m_cnt[k] + s;
        if (t > L) begin
          e = 1'b1;
          m_cnt[k] = satm[k] ? L : t - (L + 1);
        end else m_cnt[k] = t;
      end else begin
        if (s <= m_cnt[k]) m_cnt[k] = m_cnt[k] - s;
        else begin
          e = 1'b1;
          m_cnt[k] = satm[k] ? 0 : m_cnt[k] + (L + 1) - s;
        end
      end
    end
    m_tc[k] = e;
    if (e) m_ovf[k] = 1'b1;
    else if (clr_v[k]) m_ovf[k] = 1'b0;
  endfunction

  // Apply the current inputs for one edge: record expectations, then wait past the edge.
  task automatic tick();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      model(k);
      e.count = m_cnt[k];
      e.tc    = m_tc[k];
      e.ovf   = m_ovf[k];
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(negedge clk);
    #2;
  endtask

  task automatic idle(int k);
    rst_v[k]  = 1'b0;
    ena_v[k]  = 1'b0;
    sclr_v[k] = 1'b0;
    load_v[k] = 1'b0;
    dir_v[k]  = 1'b0;
    clr_v[k]  = 1'b0;
    step_v[k] = '0;
    lv_v[k]   = '0;
  endtask

  task automatic do_load(int k, int v);
    idle(k);
    load_v[k] = 1'b1;
    lv_v[k]   = 4'(v);
    tick();
    load_v[k] = 1'b0;
  endtask

  task automatic compare(int k, int ac, bit at, bit ao, exp_t e);
    vectors++;
    if (ac != e.count || at != e.tc || ao != e.ovf) begin
      miscompares++;
      $display("FAIL inst%0d vec %0d @%0t: count/tc/ovf got %0d/%0b/%0b, want %0d/%0b/%0b",
               k, vectors, $time, ac, at, ao, e.count, e.tc, e.ovf);
    end
    assert (ac <= lim[k])
    else begin
      miscompares++;
      $display("FAIL inst%0d range @%0t: count %0d above limit %0d", k, $time, ac, lim[k]);
    end
  endtask

  // Monitor: every falling edge presents a new output word; check it against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q0.size() != 0) begin
        e = q0.pop_front();
        compare(0, int'(cnt0), tc0, ovf0, e);
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        compare(1, int'(cnt1), tc1, ovf1, e);
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      idle(k);
      rst_v[k] = 1'b1;
      m_cnt[k] = 0;
      m_tc[k]  = 1'b0;
      m_ovf[k] = 1'b0;
    end
    tick();
    tick();
    idle(0);
    idle(1);

    // Wrap up by 2 from 0 through LIMIT=5.
    ena_v[0] = 1'b1;
    step_v[0] = 4'd2;
    repeat (6) tick();

    // Wrap down from 1 by 3.
    do_load(0, 1);
    ena_v[0] = 1'b1;
    dir_v[0] = 1'b1;
    step_v[0] = 4'd3;
    tick();

    // Priority and clamping.
    do_load(0, 4);
    sclr_v[0] = 1'b1; load_v[0] = 1'b1; ena_v[0] = 1'b1; lv_v[0] = 4'd2;
    tick();
    idle(0);
    load_v[0] = 1'b1; ena_v[0] = 1'b1; lv_v[0] = 4'd7;
    tick();
    idle(0);
    sclr_v[0] = 1'b1;
    tick();
    idle(0);
    ena_v[0] = 1'b1; step_v[0] = 4'd7;
    repeat (2) tick();

    // Reset mid-operation, then held reset ignores ena/load.
    do_load(0, 3);
    rst_v[0] = 1'b1; ena_v[0] = 1'b1; step_v[0] = 4'd1;
    tick();
    load_v[0] = 1'b1; lv_v[0] = 4'd4;
    repeat (2) tick();

    // Hold with ena=0, then zero step with ena=1.
    do_load(0, 2);
    repeat (5) tick();
    ena_v[0] = 1'b1;
    repeat (3) tick();

    // Saturating down on the 4-bit instance, with clr_ovf interplay.
    idle(0);
    do_load(1, 5);
    ena_v[1] = 1'b1; dir_v[1] = 1'b1; step_v[1] = 4'd3;
    repeat (2) tick();
    clr_v[1] = 1'b1;
    tick();
    ena_v[1] = 1'b0;
    tick();
    idle(1);
    ena_v[1] = 1'b1; step_v[1] = 4'd15; lv_v[1] = 4'd14;
    repeat (3) tick();

    // Random traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        rst_v[k]  = ($urandom_range(0, 63) == 0);
        sclr_v[k] = ($urandom_range(0, 15) == 0);
        load_v[k] = ($urandom_range(0, 7) == 0);
        ena_v[k]  = ($urandom_range(0, 3) != 0);
        dir_v[k]  = 1'($urandom_range(0, 1));
        clr_v[k]  = ($urandom_range(0, 7) == 0);
        step_v[k] = 4'($urandom_range(0, mask[k]));
        lv_v[k]   = 4'($urandom_range(0, mask[k]));
      end
      tick();
    end

    idle(0);
    idle(1);
    for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    #3;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expectations left, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
